// File: rtl/tlk_err_monitor.sv
// TLK link error monitor: collects per-channel error reports during a live
// window and produces a registered pass/fail/timeout verdict.
module tlk_err_monitor #(
    parameter int N_CH  = 5,
    parameter int TMO_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_live,
    input  logic [N_CH-1:0]  ch_enable,
    input  logic [N_CH-1:0]  got_err,
    input  logic [N_CH-1:0]  is_err,
    input  logic [TMO_W-1:0] tmo_limit,
    output logic             is_tlk_err,
    output logic             check_done,
    output logic             check_timeout,
    output logic [N_CH-1:0]  ch_status,
    output logic [N_CH-1:0]  ch_result,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_TMO     = 2'd3;

    localparam logic [TMO_W-1:0] TMR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [1:0]       state_q;
    logic [N_CH-1:0]  en_q;
    logic [TMO_W-1:0] timer_q;

    logic [N_CH-1:0]  rpt;
    logic [N_CH-1:0]  status_nxt;
    logic [N_CH-1:0]  result_nxt;
    logic             complete;
    logic [TMO_W-1:0] timer_nxt;
    logic             tmo_hit;
    logic             verdict_err;
    logic [CNT_W-1:0] cnt_inc;

    // Completion looks at this cycle's reports so the last report finishes the run.
    always_comb begin
        rpt         = en_q & got_err;
        status_nxt  = ch_status | rpt;
        result_nxt  = (ch_result & ~rpt) | (is_err & rpt);
        complete    = &(status_nxt | ~en_q);
        timer_nxt   = (&timer_q) ? timer_q : timer_q + TMR_ONE;
        tmo_hit     = (tmo_limit != '0) && (timer_nxt >= tmo_limit);
        verdict_err = |(result_nxt & en_q);
        cnt_inc     = (&err_count) ? err_count : err_count + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            en_q          <= '0;
            timer_q       <= '0;
            is_tlk_err    <= 1'b1;
            check_done    <= 1'b0;
            check_timeout <= 1'b0;
            ch_status     <= '0;
            ch_result     <= '0;
            err_count     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_live) begin
                        state_q <= S_COLLECT;
                        en_q    <= ch_enable;
                        timer_q <= '0;
                    end
                end
                S_COLLECT: begin
                    if (!in_live) begin
                        state_q    <= S_IDLE;
                        timer_q    <= '0;
                        ch_status  <= '0;
                        ch_result  <= '0;
                        is_tlk_err <= 1'b1;
                    end else begin
                        ch_status <= status_nxt;
                        ch_result <= result_nxt;
                        timer_q   <= timer_nxt;
                        if (complete) begin
                            state_q    <= S_DONE;
                            check_done <= 1'b1;
                            is_tlk_err <= verdict_err;
                            if (verdict_err)
                                err_count <= cnt_inc;
                        end else if (tmo_hit) begin
                            state_q       <= S_TMO;
                            check_timeout <= 1'b1;
                            is_tlk_err    <= 1'b1;
                            err_count     <= cnt_inc;
                        end
                    end
                end
                S_DONE, S_TMO: begin
                    if (!in_live) begin
                        state_q       <= S_IDLE;
                        timer_q       <= '0;
                        ch_status     <= '0;
                        ch_result     <= '0;
                        is_tlk_err    <= 1'b1;
                        check_done    <= 1'b0;
                        check_timeout <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/tlk_err_monitor.md
TLK_ERR_MONITOR -- requirements
Module: tlk_err_monitor

Interface
REQ-001 Parameter N_CH, default 5, number of TLK/link channels checked (1..32).
REQ-002 Parameter TMO_W, default 16, width of timeout timer and limit.
REQ-003 Parameter CNT_W, default 8, width of saturating error-verdict counter.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_live  input  1  live window; low = idle/clear, high = check run.
REQ-007 ch_enable  input  N_CH  per-channel participation mask; latched at run start.
REQ-008 got_err  input  N_CH  per-channel report strobe; one-cycle pulse carrying is_err.
REQ-009 is_err  input  N_CH  per-channel error flag, valid when matching got_err bit high.
REQ-010 tmo_limit  input  TMO_W  run timeout in clk cycles; 0 disables timeout.
REQ-011 is_tlk_err  output  1  registered verdict; 1 = error or undecided.
REQ-012 check_done  output  1  high while a complete verdict is held.
REQ-013 check_timeout  output  1  high while a timeout verdict is held.
REQ-014 ch_status  output  N_CH  per-channel "reported this run" flags.
REQ-015 ch_result  output  N_CH  per-channel latest reported error flag.
REQ-016 err_count  output  CNT_W  saturating count of error verdicts since reset.

Function
REQ-017 FSM states IDLE, COLLECT, DONE, TMO; one-hot or binary, registered.
REQ-018 IDLE: is_tlk_err=1, check_done=0, check_timeout=0, ch_status=0, ch_result=0, timer=0.
REQ-019 IDLE -> COLLECT on first cycle in_live=1; ch_enable latched into en_q that cycle; got_err that cycle ignored.
REQ-020 COLLECT: per channel i with en_q[i]=1 and got_err[i]=1, set ch_status[i]=1 and ch_result[i]=is_err[i]; later reports overwrite ch_result[i].
REQ-021 got_err on disabled channels ignored; their ch_status/ch_result stay 0.
REQ-022 Completion = (ch_status | ~en_q) all ones, evaluated on next-state values, so a report completes the run in its own cycle.
REQ-023 On completion: DONE next edge, check_done=1, is_tlk_err = OR(ch_result & en_q); latency 1 cycle after last report.
REQ-024 en_q all zero: completion in first COLLECT cycle, is_tlk_err=0.
REQ-025 Timer increments each COLLECT cycle; if tmo_limit!=0 and timer reaches tmo_limit without completion: TMO, check_timeout=1, is_tlk_err=1.
REQ-026 Completion and timeout same cycle: completion wins (DONE).
REQ-027 DONE/TMO: outputs held, further got_err ignored, until in_live=0 -> IDLE.
REQ-028 in_live=0 in COLLECT: IDLE next edge, run aborted, no verdict, err_count unchanged.
REQ-029 err_count +1 on each entry into DONE with is_tlk_err=1 or into TMO; saturates at all ones; cleared only by reset.
REQ-030 Timer saturates at all ones; no wrap.

Reset
REQ-031 reset=1 at any clock edge, any state: state=IDLE, is_tlk_err=1, check_done=0, check_timeout=0, ch_status=0, ch_result=0, en_q=0, timer=0, err_count=0.
REQ-032 reset overrides all inputs the same cycle; run in progress discarded.

Verification
REQ-033 N_CH=5, en=5'h1F, in_live=1, got_err pulses ch0..ch4 (is_err=0), one per cycle -> check_done=1 and is_tlk_err=0 one cycle after ch4 pulse, err_count=0.
REQ-034 Same run, ch2 reports is_err=1 then re-reports is_err=0 before ch4 -> ch_result=0, is_tlk_err=0; variant without re-report -> is_tlk_err=1, err_count=1.
REQ-035 en=5'b10111, only ch0,1,2,4 report clean, ch3 pulses is_err=1 -> DONE, is_tlk_err=0, ch_status=5'b10111.
REQ-036 tmo_limit=10, ch4 never reports -> TMO after 10 COLLECT cycles, check_timeout=1, is_tlk_err=1, err_count+1; last report on cycle 10 -> DONE instead.
REQ-037 reset or in_live=0 mid-COLLECT with 3 channels reported -> IDLE next edge, ch_status=0, is_tlk_err=1; err_count preserved on in_live drop, 0 on reset.
REQ-038 CNT_W=2, four consecutive error runs -> err_count 1,2,3,3.
